absorb_fsm: RTL and testbench

- Second-stage controller of the SHAKE pipeline.
- Consumes blocks published by the load stage through the input_buffer_ready flag and XORs each block into the Keccak state.
- Sequences the Keccak-f round datapath, then hands the squeezed rate portion to the output stage through an output_buffer_ready flag handshake.
- Repeats squeeze permutations until the output stage reports the final output block.

---
 rtl/absorb_fsm.sv | 153 +++++++++++++++
 tb/tb_absorb_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/absorb_fsm.sv
// absorb_fsm: second-stage SHAKE controller.
// Absorbs blocks from the input buffer into the Keccak state, sequences the
// one-round-per-cycle Keccak-f datapath, and hands squeezed rate blocks to
// the output stage through the output_buffer_ready flag handshake.
// Control outputs are decoded from the current state and inputs (Mealy) so
// the datapath acts in the same cycle the condition is seen.
module absorb_fsm #(
  parameter int ROUNDS = 24,
  parameter int RW     = $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          input_buffer_ready,
  input  logic          last_block_in_buffer,
  output logic          input_buffer_ready_clr,
  output logic          state_reset,
  output logic          absorb_enable,
  output logic          round_enable,
  output logic [RW-1:0] round_index,
  input  logic          output_buffer_ready,
  input  logic          last_output_block,
  output logic          copy_enable,
  output logic          output_buffer_ready_wr,
  output logic          last_block_out_wr,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_IDLE        = 3'd1,
    ST_PERMUTE     = 3'd2,
    ST_WAIT_OUTPUT = 3'd3,
    ST_COPY        = 3'd4
  } state_t;

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  state_t        state_r;
  logic [RW-1:0] round_r;
  logic          last_absorbed_r;

  assign round_index = round_r;

  // State register, round counter and last-block tracking; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_RESET;
      round_r         <= '0;
      last_absorbed_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET: begin
          state_r <= ST_IDLE;
        end
        ST_IDLE: begin
          if (input_buffer_ready) begin
            last_absorbed_r <= last_block_in_buffer;
            round_r         <= '0;
            state_r         <= ST_PERMUTE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PERMUTE: begin
          if (round_r == LAST_ROUND) begin
            round_r <= '0;
            if (!last_absorbed_r) begin
              state_r <= ST_IDLE;
            end else if (output_buffer_ready) begin
              // Output buffer still unread: hold the block until it drains.
              state_r <= ST_WAIT_OUTPUT;
            end else begin
              // Output buffer already free: copy right after the last round.
              state_r <= ST_COPY;
            end
          end else begin
            round_r <= round_r + RW'(1);
          end
        end
        ST_WAIT_OUTPUT: begin
          if (!output_buffer_ready) begin
            state_r <= ST_COPY;
          end else begin
            state_r <= ST_WAIT_OUTPUT;
          end
        end
        ST_COPY: begin
          round_r <= '0;
          if (last_output_block) begin
            last_absorbed_r <= 1'b0;
            state_r         <= ST_IDLE;
          end else begin
            // Squeeze permutation for the next output block.
            state_r <= ST_PERMUTE;
          end
        end
        default: begin
          state_r         <= ST_RESET;
          round_r         <= '0;
          last_absorbed_r <= 1'b0;
        end
      endcase
    end
  end

  // Mealy decode of the datapath controls and handshake pulses.
  always_comb begin
    input_buffer_ready_clr = 1'b0;
    state_reset            = 1'b0;
    absorb_enable          = 1'b0;
    round_enable           = 1'b0;
    copy_enable            = 1'b0;
    output_buffer_ready_wr = 1'b0;
    last_block_out_wr      = 1'b0;
    busy                   = 1'b1;
    case (state_r)
      ST_RESET: begin
        state_reset = 1'b1;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (input_buffer_ready) begin
          absorb_enable          = 1'b1;
          input_buffer_ready_clr = 1'b1;
        end else begin
          absorb_enable          = 1'b0;
          input_buffer_ready_clr = 1'b0;
        end
      end
      ST_PERMUTE: begin
        round_enable = 1'b1;
      end
      ST_WAIT_OUTPUT: begin
        busy = 1'b1;
      end
      ST_COPY: begin
        copy_enable            = 1'b1;
        output_buffer_ready_wr = 1'b1;
        last_block_out_wr      = last_output_block;
        // The copy samples the pre-reset state on the same edge the state clears.
        if (last_output_block) begin
          state_reset = 1'b1;
        end else begin
          state_reset = 1'b0;
        end
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_absorb_fsm.sv
// Directed testbench for absorb_fsm: inputs change just after the falling
// edge, outputs are checked 1 time unit later, well away from the rising edge.
module tb_absorb_fsm;

  localparam int ROUNDS = 24;
  localparam int RW     = 5;

  // Bit positions in the packed output vector
  localparam logic [7:0] O_SR   = 8'b1000_0000; // state_reset
  localparam logic [7:0] O_ABS  = 8'b0100_0000; // absorb_enable
  localparam logic [7:0] O_CLR  = 8'b0010_0000; // input_buffer_ready_clr
  localparam logic [7:0] O_RE   = 8'b0001_0000; // round_enable
  localparam logic [7:0] O_CP   = 8'b0000_1000; // copy_enable
  localparam logic [7:0] O_OBW  = 8'b0000_0100; // output_buffer_ready_wr
  localparam logic [7:0] O_LBW  = 8'b0000_0010; // last_block_out_wr
  localparam logic [7:0] O_BUSY = 8'b0000_0001; // busy

  logic          clk;
  logic          rst;
  logic          input_buffer_ready;
  logic          last_block_in_buffer;
  logic          input_buffer_ready_clr;
  logic          state_reset;
  logic          absorb_enable;
  logic          round_enable;
  logic [RW-1:0] round_index;
  logic          output_buffer_ready;
  logic          last_output_block;
  logic          copy_enable;
  logic          output_buffer_ready_wr;
  logic          last_block_out_wr;
  logic          busy;

  int checks;
  int errors;

  logic [7:0] outs;
  assign outs = {state_reset, absorb_enable, input_buffer_ready_clr, round_enable,
                 copy_enable, output_buffer_ready_wr, last_block_out_wr, busy};

  absorb_fsm #(.ROUNDS(ROUNDS), .RW(RW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .input_buffer_ready     (input_buffer_ready),
    .last_block_in_buffer   (last_block_in_buffer),
    .input_buffer_ready_clr (input_buffer_ready_clr),
    .state_reset            (state_reset),
    .absorb_enable          (absorb_enable),
    .round_enable           (round_enable),
    .round_index            (round_index),
    .output_buffer_ready    (output_buffer_ready),
    .last_output_block      (last_output_block),
    .copy_enable            (copy_enable),
    .output_buffer_ready_wr (output_buffer_ready_wr),
    .last_block_out_wr      (last_block_out_wr),
    .busy                   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // 24 permutation cycles: only round_enable and busy, round_index counts 0..23.
  task automatic perm(input string tag);
    for (int i = 0; i < ROUNDS; i++) begin
      step();
      #1;
      chk({tag, "_outs"}, 32'(outs), 32'(O_RE | O_BUSY));
      chk({tag, "_ridx"}, 32'(round_index), 32'(i));
    end
  endtask

  initial begin
    checks               = 0;
    errors               = 0;
    rst                  = 1'b1;
    input_buffer_ready   = 1'b0;
    last_block_in_buffer = 1'b0;
    output_buffer_ready  = 1'b0;
    last_output_block    = 1'b0;

    // ---- Reset: 3 cycles high, then exactly one RESET cycle, then IDLE
    step(); step(); step();
    step(); rst = 1'b0; #1;
    chk("reset_cycle", 32'(outs), 32'(O_SR | O_BUSY));
    chk("reset_ridx", 32'(round_index), 32'd0);
    step(); #1;
    chk("idle_after_reset", 32'(outs), 32'd0);
    chk("idle_ridx", 32'(round_index), 32'd0);
    step(); #1;
    chk("idle_stays", 32'(outs), 32'd0);

    // ---- Single-block message, single-block output
    step();
    input_buffer_ready = 1'b1; last_block_in_buffer = 1'b1;
    output_buffer_ready = 1'b0; last_output_block = 1'b1;
    #1;
    chk("t1_absorb", 32'(outs), 32'(O_ABS | O_CLR));
    step(); input_buffer_ready = 1'b0; #1;
    chk("t1_r0", 32'(outs), 32'(O_RE | O_BUSY));
    for (int i = 1; i < ROUNDS; i++) begin
      step(); #1;
      chk("t1_perm", 32'(round_index), 32'(i));
    end
    step(); #1;
    chk("t1_copy", 32'(outs), 32'(O_SR | O_CP | O_OBW | O_LBW | O_BUSY));
    step(); #1;
    chk("t1_idle", 32'(outs), 32'd0);

    // ---- Three-block message; flag refilled during each permutation
    last_output_block = 1'b1;
    input_buffer_ready = 1'b1; last_block_in_buffer = 1'b0; #1;
    chk("t2_abs1", 32'(outs), 32'(O_ABS | O_CLR));
    step(); input_buffer_ready = 1'b0; #1;
    chk("t2_p1_r0", 32'(outs), 32'(O_RE | O_BUSY));
    for (int i = 1; i < ROUNDS; i++) begin
      step();
      if (i == 10) input_buffer_ready = 1'b1;
      #1;
      chk("t2_p1_ignore_ibr", 32'(outs), 32'(O_RE | O_BUSY));
    end
    step(); #1;
    chk("t2_abs2", 32'(outs), 32'(O_ABS | O_CLR));
    step(); input_buffer_ready = 1'b0; last_block_in_buffer = 1'b1; #1;
    chk("t2_p2_r0", 32'(round_index), 32'd0);
    for (int i = 1; i < ROUNDS; i++) begin
      step();
      if (i == 5) input_buffer_ready = 1'b1;
      #1;
      chk("t2_p2", 32'(outs), 32'(O_RE | O_BUSY));
    end
    step(); #1;
    chk("t2_abs3", 32'(outs), 32'(O_ABS | O_CLR));
    step(); input_buffer_ready = 1'b0; #1;
    chk("t2_p3_r0", 32'(outs), 32'(O_RE | O_BUSY));
    for (int i = 1; i < ROUNDS; i++) begin
      step(); #1;
      chk("t2_p3", 32'(round_index), 32'(i));
    end
    step(); #1;
    chk("t2_copy", 32'(outs), 32'(O_SR | O_CP | O_OBW | O_LBW | O_BUSY));
    step(); #1;
    chk("t2_idle", 32'(outs), 32'd0);
    step(); #1;
    chk("t2_no_extra_perm", 32'(outs), 32'd0);

    // ---- Output backpressure: output buffer busy for 10 cycles after the permutation
    input_buffer_ready = 1'b1; last_block_in_buffer = 1'b1;
    output_buffer_ready = 1'b1; last_output_block = 1'b1; #1;
    chk("t3_absorb", 32'(outs), 32'(O_ABS | O_CLR));
    step(); input_buffer_ready = 1'b0;
    for (int i = 1; i < ROUNDS; i++) step();
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      chk("t3_wait", 32'(outs), 32'(O_BUSY));
    end
    step(); output_buffer_ready = 1'b0; #1;
    chk("t3_wait_drop", 32'(outs), 32'(O_BUSY));
    step(); #1;
    chk("t3_copy", 32'(outs), 32'(O_SR | O_CP | O_OBW | O_LBW | O_BUSY));
    step(); #1;
    chk("t3_idle", 32'(outs), 32'd0);

    // ---- Three output blocks, last only on the third copy
    input_buffer_ready = 1'b1; last_block_in_buffer = 1'b1;
    output_buffer_ready = 1'b0; last_output_block = 1'b0; #1;
    chk("t4_absorb", 32'(outs), 32'(O_ABS | O_CLR));
    step(); input_buffer_ready = 1'b0;
    for (int i = 1; i < ROUNDS; i++) step();
    step(); #1;
    chk("t4_copy1", 32'(outs), 32'(O_CP | O_OBW | O_BUSY));
    perm("t4_sq1");
    step(); #1;
    chk("t4_copy2", 32'(outs), 32'(O_CP | O_OBW | O_BUSY));
    perm("t4_sq2");
    step(); last_output_block = 1'b1; #1;
    chk("t4_copy3", 32'(outs), 32'(O_SR | O_CP | O_OBW | O_LBW | O_BUSY));
    step(); #1;
    chk("t4_idle", 32'(outs), 32'd0);

    // ---- rst mid-permutation at round_index 12, with a pending input block
    input_buffer_ready = 1'b1; last_block_in_buffer = 1'b0; #1;
    chk("t5_absorb", 32'(outs), 32'(O_ABS | O_CLR));
    step(); input_buffer_ready = 1'b0;
    for (int i = 1; i < 12; i++) step();
    step(); rst = 1'b1; input_buffer_ready = 1'b1; #1;
    chk("t5_ridx12", 32'(round_index), 32'd12);
    step(); rst = 1'b0; #1;
    chk("t5_reset_outs", 32'(outs), 32'(O_SR | O_BUSY));
    chk("t5_reset_ridx", 32'(round_index), 32'd0);
    step(); #1;
    chk("t5_pending_absorb", 32'(outs), 32'(O_ABS | O_CLR));
    step(); input_buffer_ready = 1'b0; #1;
    chk("t5_perm_r0", 32'(outs), 32'(O_RE | O_BUSY));
    chk("t5_perm_ridx", 32'(round_index), 32'd0);
    for (int i = 1; i < ROUNDS; i++) step();
    step(); #1;
    chk("t5_back_idle", 32'(outs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
